// File: rtl/exec_unit_if.sv
// Issue and CDB broadcast signals between the reservation station and exec_unit.
// master: station/CDB side; slave: the execution unit.
interface exec_unit_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned OP_W   = 2;

    logic              inValid;
    logic [OP_W-1:0]   opIn;
    logic [DATA_W-1:0] dataIn1;
    logic [DATA_W-1:0] dataIn2;
    logic [TAG_W-1:0]  labelIn;
    logic              EXEable;
    logic              BCreq;
    logic              BCgrant;
    logic [TAG_W-1:0]  BClabel;
    logic [DATA_W-1:0] BCdata;

    modport master (
        output inValid, opIn, dataIn1, dataIn2, labelIn, BCgrant,
        input  EXEable, BCreq, BClabel, BCdata
    );

    modport slave (
        input  inValid, opIn, dataIn1, dataIn2, labelIn, BCgrant,
        output EXEable, BCreq, BClabel, BCdata
    );
endinterface

// File: rtl/exec_unit.sv
// Single-issue integer execution unit with a 2-entry CDB result buffer.
// Define EXEC_MUL_EN for a 3-cycle MUL on op 11; otherwise op 11 is a 1-cycle OR.
module exec_unit (
    input  logic       clk,
    input  logic       RST,
    exec_unit_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    logic [1:0]        count_q;
    logic              wp_q;
    logic              rp_q;
    logic [TAG_W-1:0]  lbl_q [2];
    logic [DATA_W-1:0] dat_q [2];

    logic              accept;
    logic              push;
    logic              pop;
    logic [TAG_W-1:0]  push_lbl;
    logic [DATA_W-1:0] push_dat;
    logic [DATA_W-1:0] alu_res;
    logic              room;

    assign room   = (count_q < 2'd2);
    assign accept = bus.inValid & bus.EXEable;
    assign pop    = (count_q != 2'd0) & bus.BCgrant;

    // Single-cycle datapath; op 11 is handled by the multiplier when enabled
    always_comb begin
        alu_res = '0;
        case (bus.opIn)
            OP_ADD:  alu_res = bus.dataIn1 + bus.dataIn2;
            OP_SUB:  alu_res = bus.dataIn1 - bus.dataIn2;
            OP_AND:  alu_res = bus.dataIn1 & bus.dataIn2;
            default: begin
`ifdef EXEC_MUL_EN
                alu_res = '0;
`else
                alu_res = bus.dataIn1 | bus.dataIn2;
`endif
            end
        endcase
    end

`ifdef EXEC_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_e;

    state_e            state_q;
    logic [1:0]        cnt_q;
    logic [DATA_W-1:0] mul_a_q;
    logic [DATA_W-1:0] mul_b_q;
    logic [TAG_W-1:0]  mul_tag_q;
    logic              mul_done;

    assign mul_done    = (state_q == S_MUL) && (cnt_q == 2'd0);
    assign bus.EXEable = !RST && (state_q == S_IDLE) && room;

    // MUL sequencer: operands latched at accept, result ready when the counter hits 0
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q   <= S_IDLE;
            cnt_q     <= 2'd0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
            mul_tag_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept && (bus.opIn == OP_MUL)) begin
                        mul_a_q   <= bus.dataIn1;
                        mul_b_q   <= bus.dataIn2;
                        mul_tag_q <= bus.labelIn;
                        cnt_q     <= 2'd2;
                        state_q   <= S_MUL;
                    end
                end
                S_MUL: begin
                    if (cnt_q == 2'd0) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Tag 0 still runs the op but its result is dropped
    always_comb begin
        push     = 1'b0;
        push_lbl = '0;
        push_dat = '0;
        if (mul_done) begin
            push     = (mul_tag_q != '0);
            push_lbl = mul_tag_q;
            push_dat = DATA_W'(mul_a_q * mul_b_q);
        end else if (accept && (bus.opIn != OP_MUL)) begin
            push     = (bus.labelIn != '0);
            push_lbl = bus.labelIn;
            push_dat = alu_res;
        end
    end
`else
    assign bus.EXEable = !RST && room;

    always_comb begin
        push     = accept && (bus.labelIn != '0);
        push_lbl = bus.labelIn;
        push_dat = alu_res;
    end
`endif

    // Result FIFO; a push into an empty buffer is not visible to the same-cycle grant
    always_ff @(posedge clk) begin
        if (RST) begin
            count_q  <= 2'd0;
            wp_q     <= 1'b0;
            rp_q     <= 1'b0;
            lbl_q[0] <= '0;
            lbl_q[1] <= '0;
            dat_q[0] <= '0;
            dat_q[1] <= '0;
        end else begin
            if (push) begin
                lbl_q[wp_q] <= push_lbl;
                dat_q[wp_q] <= push_dat;
                wp_q        <= ~wp_q;
            end
            if (pop) begin
                rp_q <= ~rp_q;
            end
            count_q <= count_q + 2'(push) - 2'(pop);
        end
    end

    assign bus.BCreq   = (count_q != 2'd0);
    assign bus.BClabel = bus.BCreq ? lbl_q[rp_q] : '0;
    assign bus.BCdata  = bus.BCreq ? dat_q[rp_q] : '0;

endmodule
